id_exe_reg: RTL
===============

Name: id_exe_reg

Overview:
Pipeline register between the decode stage and the execute stage of the ARM pipeline. It captures every decode output on each clock edge. It inserts bubbles on a taken-branch flush and holds its contents during a whole-pipeline freeze (memory stall). It also keeps saturating flush and bubble counters for performance debug.

Parameters:
N, 32, datapath width (PC, register values)
CNT_W, 16, width of the flush and bubble statistics counters

Ports:
clk  input  1  pipeline clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  taken branch resolved in EXE; the entry being captured is wrong-path
freeze  input  1  whole-pipeline stall; register holds all contents
PCIn  input  N  PC+4 from decode
val_RnIn  input  N  register-file read data for Rn
val_RmIn  input  N  register-file read data for Rm/Rd
Two_srcIn  input  1  instruction reads two sources
SIn  input  1  update-status request
BIn  input  1  branch
EXE_CMDIn  input  4  ALU command
MEM_W_ENIn  input  1  store
MEM_R_ENIn  input  1  load
WB_ENIn  input  1  register writeback enable
DestIn  input  4  destination register
iIn  input  1  immediate flag
RnIn  input  4  source register 1 index
src2In  input  4  source register 2 index
shiftOperandIn  input  12  shifter operand field
immIn  input  24  signed branch offset field
statusIn  input  4  NZCV flags from the status register
(each input above has a matching registered output with suffix Out, same width)
validOut  output  1  1 = entry is a real (non-bubble) instruction
flushCountOut  output  CNT_W  number of flush-inserted bubbles
bubbleCountOut  output  CNT_W  number of captured entries with all control bits zero

Behaviour:
- Latency: exactly 1 cycle from inputs to the Out ports when no freeze is active.
- Control group: SOut, BOut, EXE_CMDOut, MEM_W_ENOut, MEM_R_ENOut, WB_ENOut, validOut.
- Data group: all other Out ports.
- Priority at each rising edge: rst > flush > freeze > load.
- rst: every Out port and both counters go to 0. validOut is 0.
- flush (regardless of freeze): control group is cleared to 0. Data group is also cleared to 0 for deterministic waveforms. flushCountOut increments.
- freeze (and no flush): every register, including the counters, holds its value.
- Load (no rst, no flush, no freeze): all Out ports take the input values.
  - validOut is set to 1 when any control input bit is nonzero (SIn, BIn, MEM_W_ENIn, MEM_R_ENIn, WB_ENIn, or EXE_CMDIn != 0). Otherwise validOut is 0.
  - When the loaded control group is all zero (a decode-inserted hazard or condition-fail bubble), bubbleCountOut increments.
- Counters saturate at all-ones and never wrap.
- A flush does not increment bubbleCountOut.
- A held entry is never counted twice.
- Reset applied mid-stall or together with flush still produces the full reset state.
- No combinational path exists from any input to any output.

Decomposition:
- Shared package holds:
  - field widths: CMD_W=4, REG_W=4, SHOP_W=12, IMM_W=24, FLAG_W=4
  - EXE_CMD constant NOP=4'b0000
  - the control-group bundle layout, 9 bits: {WB, MEM_R, MEM_W, B, S, EXE_CMD}
- One sub-module, pipe_field_reg: parameterized width, with ports clk, rst, clr, en, d, q. It is instantiated once for the control bundle and once per data field.
- Counters are implemented inline.

Test Plan:
- Reset: assert rst for 2 cycles with all inputs at 1s -> every Out port, validOut, and both counters read 0.
- Load: PCIn=32'h0000_0010, EXE_CMDIn=4'b0001, WB_ENIn=1, DestIn=4'd3, then one edge -> PCOut=32'h10, EXE_CMDOut=1, WB_ENOut=1, DestOut=3, validOut=1 on the next cycle.
- Freeze: hold freeze=1 for 3 cycles while inputs change to PCIn=32'h20 -> Out ports stay at the 32'h10 values. After freeze drops, one edge -> PCOut=32'h20.
- Flush over freeze: flush=1 and freeze=1 together on an entry with MEM_R_ENIn=1 -> control group 0, validOut=0, flushCountOut increments 0->1, bubbleCountOut unchanged.
- Bubble: load with all control inputs 0 on 3 non-frozen edges, with a 2-cycle freeze in between -> bubbleCountOut=3, validOut=0.
- Saturation: with CNT_W=2, apply 5 flushes -> flushCountOut stays at 3.

Source files
------------

// File: rtl/id_exe_reg_pkg.sv
// Shared field widths and control-bundle layout for the decode/execute pipeline register.
package id_exe_reg_pkg;
  localparam int CMD_W  = 4;
  localparam int REG_W  = 4;
  localparam int SHOP_W = 12;
  localparam int IMM_W  = 24;
  localparam int FLAG_W = 4;

  localparam logic [CMD_W-1:0] NOP = 4'b0000;

  // Control bundle, MSB first: {WB, MEM_R, MEM_W, B, S, EXE_CMD}
  typedef struct packed {
    logic             wb;
    logic             mem_r;
    logic             mem_w;
    logic             b;
    logic             s;
    logic [CMD_W-1:0] exe_cmd;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic ctrl_active(input ctrl_t c);
    return |c;
  endfunction
endpackage

// File: rtl/id_exe_reg_if.sv
// Decode-side inputs and execute-side outputs of the ID/EXE pipeline register.
interface id_exe_reg_if #(parameter int N = 32, parameter int CNT_W = 16);
  import id_exe_reg_pkg::*;

  logic [N-1:0]      PCIn, val_RnIn, val_RmIn;
  logic              Two_srcIn, SIn, BIn, MEM_W_ENIn, MEM_R_ENIn, WB_ENIn, iIn;
  logic [CMD_W-1:0]  EXE_CMDIn;
  logic [REG_W-1:0]  DestIn, RnIn, src2In;
  logic [SHOP_W-1:0] shiftOperandIn;
  logic [IMM_W-1:0]  immIn;
  logic [FLAG_W-1:0] statusIn;

  logic [N-1:0]      PCOut, val_RnOut, val_RmOut;
  logic              Two_srcOut, SOut, BOut, MEM_W_ENOut, MEM_R_ENOut, WB_ENOut, iOut;
  logic [CMD_W-1:0]  EXE_CMDOut;
  logic [REG_W-1:0]  DestOut, RnOut, src2Out;
  logic [SHOP_W-1:0] shiftOperandOut;
  logic [IMM_W-1:0]  immOut;
  logic [FLAG_W-1:0] statusOut;
  logic              validOut;
  logic [CNT_W-1:0]  flushCountOut, bubbleCountOut;

  modport master (
    output PCIn, val_RnIn, val_RmIn, Two_srcIn, SIn, BIn, MEM_W_ENIn, MEM_R_ENIn, WB_ENIn,
           iIn, EXE_CMDIn, DestIn, RnIn, src2In, shiftOperandIn, immIn, statusIn,
    input  PCOut, val_RnOut, val_RmOut, Two_srcOut, SOut, BOut, MEM_W_ENOut, MEM_R_ENOut,
           WB_ENOut, iOut, EXE_CMDOut, DestOut, RnOut, src2Out, shiftOperandOut, immOut,
           statusOut, validOut, flushCountOut, bubbleCountOut
  );

  modport slave (
    input  PCIn, val_RnIn, val_RmIn, Two_srcIn, SIn, BIn, MEM_W_ENIn, MEM_R_ENIn, WB_ENIn,
           iIn, EXE_CMDIn, DestIn, RnIn, src2In, shiftOperandIn, immIn, statusIn,
    output PCOut, val_RnOut, val_RmOut, Two_srcOut, SOut, BOut, MEM_W_ENOut, MEM_R_ENOut,
           WB_ENOut, iOut, EXE_CMDOut, DestOut, RnOut, src2Out, shiftOperandOut, immOut,
           statusOut, validOut, flushCountOut, bubbleCountOut
  );
endinterface

// File: rtl/id_exe_reg_pipe_field_reg.sv
// One pipeline field: sync reset, clear (bubble insert), enable (hold when low).
module pipe_field_reg #(parameter int W = 1) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en)    q <= d;
  end
endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with flush bubbles, freeze hold and saturating flush/bubble counters.
module id_exe_reg
  import id_exe_reg_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        freeze,
  id_exe_reg_if.slave bus
);
  ctrl_t ctrl_d, ctrl_q;
  logic  valid_d, valid_q, en;
  logic [CNT_W-1:0] flush_cnt, bubble_cnt;

  assign en      = ~freeze;
  assign ctrl_d  = '{wb: bus.WB_ENIn, mem_r: bus.MEM_R_ENIn, mem_w: bus.MEM_W_ENIn,
                     b: bus.BIn, s: bus.SIn, exe_cmd: bus.EXE_CMDIn};
  assign valid_d = ctrl_active(ctrl_d);

  // valid rides with the control bundle so a flush clears both together
  pipe_field_reg #(.W(CTRL_W+1)) u_ctrl (.clk, .rst, .clr(flush), .en,
    .d({valid_d, ctrl_d}), .q({valid_q, ctrl_q}));

  pipe_field_reg #(.W(N))      u_pc   (.clk, .rst, .clr(flush), .en, .d(bus.PCIn),           .q(bus.PCOut));
  pipe_field_reg #(.W(N))      u_rnv  (.clk, .rst, .clr(flush), .en, .d(bus.val_RnIn),       .q(bus.val_RnOut));
  pipe_field_reg #(.W(N))      u_rmv  (.clk, .rst, .clr(flush), .en, .d(bus.val_RmIn),       .q(bus.val_RmOut));
  pipe_field_reg #(.W(1))      u_two  (.clk, .rst, .clr(flush), .en, .d(bus.Two_srcIn),      .q(bus.Two_srcOut));
  pipe_field_reg #(.W(REG_W))  u_dest (.clk, .rst, .clr(flush), .en, .d(bus.DestIn),         .q(bus.DestOut));
  pipe_field_reg #(.W(1))      u_imm1 (.clk, .rst, .clr(flush), .en, .d(bus.iIn),            .q(bus.iOut));
  pipe_field_reg #(.W(REG_W))  u_rn   (.clk, .rst, .clr(flush), .en, .d(bus.RnIn),           .q(bus.RnOut));
  pipe_field_reg #(.W(REG_W))  u_src2 (.clk, .rst, .clr(flush), .en, .d(bus.src2In),         .q(bus.src2Out));
  pipe_field_reg #(.W(SHOP_W)) u_shop (.clk, .rst, .clr(flush), .en, .d(bus.shiftOperandIn), .q(bus.shiftOperandOut));
  pipe_field_reg #(.W(IMM_W))  u_off  (.clk, .rst, .clr(flush), .en, .d(bus.immIn),          .q(bus.immOut));
  pipe_field_reg #(.W(FLAG_W)) u_st   (.clk, .rst, .clr(flush), .en, .d(bus.statusIn),       .q(bus.statusOut));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Bubbles are counted only on a real load, so a held entry is never recounted
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      flush_cnt  <= sat_inc(flush_cnt);
    end else if (!freeze && !valid_d) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

  assign bus.WB_ENOut       = ctrl_q.wb;
  assign bus.MEM_R_ENOut    = ctrl_q.mem_r;
  assign bus.MEM_W_ENOut    = ctrl_q.mem_w;
  assign bus.BOut           = ctrl_q.b;
  assign bus.SOut           = ctrl_q.s;
  assign bus.EXE_CMDOut     = ctrl_q.exe_cmd;
  assign bus.validOut       = valid_q;
  assign bus.flushCountOut  = flush_cnt;
  assign bus.bubbleCountOut = bubble_cnt;
endmodule
